// File: rtl/dense_pkg.sv
// Shared types and constants for the dense-layer weight sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state encoding, return-FIFO depth, per-beat tag struct, clog2 helper.
package dense_pkg;

    // Ceiling log2; clog2(1) == 0, callers clamp widths to at least 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_CNT_W = clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Sideband carried through the FIFO next to each ROM word.
    typedef struct packed {
        logic is_bias;
        logic last;
        logic last_in;
    } tag_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy count; head word is read combinationally from storage.
// Latency: a word pushed at edge E is visible at the head in the cycle after E.
// Backpressure: pushes when full and pops when empty are dropped; the producer is expected to hold credit.
// Ports: i_clk, i_reset (sync, active-high), i_push/i_push_dat, i_pop/o_pop_dat, o_full, o_empty, o_count.
module sync_fifo
    import dense_pkg::*;
#(
    parameter int WIDTH = 35,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_push,
    input  logic [WIDTH-1:0]      i_push_dat,
    input  logic                  i_pop,
    output logic [WIDTH-1:0]      o_pop_dat,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [FIFO_CNT_W-1:0] o_count
);

    localparam int PTR_W = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [FIFO_CNT_W-1:0] r_count;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign o_full    = (r_count == FIFO_CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_pop_dat = r_mem[r_rd_ptr];

    assign w_do_pop  = i_pop && !o_empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO is legal then.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dense_weight_sequencer.sv
// Sole ROM master for the dense layer: streams weights row-major (neuron-major, input-minor) to the MAC.
// Latency: start at edge 0 -> ROM request in cycle 1 -> first w_valid in cycle 3; one beat/cycle sustained.
// Backpressure: 4-entry return FIFO; requests issue only while fifo_count + inflight < 4, so nothing is lost.
// Option: define DENSE_BIAS_FETCH_EN to append one bias read (BIAS_ADDR + neuron) after each neuron's weights.
// Ports: clk, reset (sync, active-high), start, busy, done, rom_addr/rom_en/rom_dout (ROM side),
//        w_data/w_valid/w_ready with tags w_is_bias, w_last_in, w_last (MAC side).
module dense_weight_sequencer
    import dense_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 19,
    parameter int IN_DIM     = 64,
    parameter int OUT_DIM    = 7,
    parameter int BASE_ADDR  = 0,
    parameter int BIAS_ADDR  = 'h4FF00
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  rom_en,
    input  logic [DATA_WIDTH-1:0] rom_dout,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic                  w_valid,
    input  logic                  w_ready,
    output logic                  w_is_bias,
    output logic                  w_last_in,
    output logic                  w_last
);

    localparam int IW    = (clog2(IN_DIM)  > 0) ? clog2(IN_DIM)  : 1;
    localparam int NW    = (clog2(OUT_DIM) > 0) ? clog2(OUT_DIM) : 1;
    localparam int FW    = DATA_WIDTH + $bits(tag_t);

    localparam longint WEIGHT_END = longint'(BASE_ADDR) + longint'(IN_DIM) * longint'(OUT_DIM);
    localparam longint BIAS_END   = longint'(BIAS_ADDR) + longint'(OUT_DIM);
    localparam longint ADDR_SPAN  = longint'(1) << ADDR_WIDTH;

    // The address incrementers never wrap, so both tables must fit the ROM.
    if (WEIGHT_END > ADDR_SPAN) begin : g_bad_weight_range
        $error("dense_weight_sequencer: weight table exceeds ROM address space");
    end
    if (BIAS_END > ADDR_SPAN) begin : g_bad_bias_range
        $error("dense_weight_sequencer: bias table exceeds ROM address space");
    end

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IW-1:0]         r_in_idx;
    logic [NW-1:0]         r_neuron_idx;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [ADDR_WIDTH-1:0] r_last_addr;
    logic [1:0]            r_inflight;
    logic                  r_rd_vld;
    tag_t                  r_rd_tag;
    logic                  r_done;

    logic                  w_start_ok;
    logic                  w_credit_ok;
    logic                  w_issue;
    logic                  w_last_input;
    logic                  w_last_neuron;
    logic [ADDR_WIDTH-1:0] w_req_addr;
    tag_t                  w_req_tag;
    logic [FW-1:0]         w_head;
    tag_t                  w_head_tag;
    logic                  w_fire;
    logic                  w_final_fire;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [FIFO_CNT_W-1:0] w_fifo_count;

    assign w_start_ok    = (r_state == ST_IDLE) && start;
    assign w_last_input  = (r_in_idx == IW'(IN_DIM - 1));
    assign w_last_neuron = (r_neuron_idx == NW'(OUT_DIM - 1));
    assign w_credit_ok   = ((4'(w_fifo_count) + 4'(r_inflight)) < 4'(FIFO_DEPTH));

`ifdef DENSE_BIAS_FETCH_EN
    logic [ADDR_WIDTH-1:0] r_baddr;
    logic                  r_bias_phase;

    // The bias request follows the neuron's last weight and owns its end-of-neuron tags.
    assign w_req_addr        = r_bias_phase ? r_baddr : r_waddr;
    assign w_req_tag.is_bias = r_bias_phase;
    assign w_req_tag.last_in = r_bias_phase;
    assign w_req_tag.last    = r_bias_phase && w_last_neuron;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_baddr      <= '0;
            r_bias_phase <= 1'b0;
        end else if (w_start_ok) begin
            r_baddr      <= ADDR_WIDTH'(BIAS_ADDR);
            r_bias_phase <= 1'b0;
        end else if (w_issue) begin
            if (r_bias_phase) begin
                r_baddr      <= r_baddr + 1'b1;
                r_bias_phase <= 1'b0;
            end else if (w_last_input) begin
                r_bias_phase <= 1'b1;
            end
        end
    end
`else
    assign w_req_addr        = r_waddr;
    assign w_req_tag.is_bias = 1'b0;
    assign w_req_tag.last_in = w_last_input;
    assign w_req_tag.last    = w_last_input && w_last_neuron;
`endif

    // Issue/index counters: weight address is a plain incrementer, no multiply.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_idx     <= '0;
            r_neuron_idx <= '0;
            r_waddr      <= '0;
        end else if (w_start_ok) begin
            r_in_idx     <= '0;
            r_neuron_idx <= '0;
            r_waddr      <= ADDR_WIDTH'(BASE_ADDR);
        end else if (w_issue) begin
`ifdef DENSE_BIAS_FETCH_EN
            if (r_bias_phase) begin
                r_neuron_idx <= r_neuron_idx + 1'b1;
            end else begin
                r_waddr  <= r_waddr + 1'b1;
                r_in_idx <= w_last_input ? '0 : r_in_idx + 1'b1;
            end
`else
            r_waddr  <= r_waddr + 1'b1;
            r_in_idx <= w_last_input ? '0 : r_in_idx + 1'b1;
            if (w_last_input) begin
                r_neuron_idx <= r_neuron_idx + 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_issue = w_credit_ok;
                if (w_credit_ok && w_req_tag.last) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_final_fire) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ROM read pipeline: request in cycle N, rom_dout valid in N+1, pushed at the end of N+1.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_vld    <= 1'b0;
            r_rd_tag    <= '0;
            r_inflight  <= '0;
            r_last_addr <= '0;
        end else begin
            r_rd_vld   <= w_issue;
            r_inflight <= r_inflight + 2'(w_issue) - 2'(r_rd_vld);
            if (w_issue) begin
                r_rd_tag    <= w_req_tag;
                r_last_addr <= w_req_addr;
            end
        end
    end

    assign rom_en   = w_issue;
    assign rom_addr = w_issue ? w_req_addr : r_last_addr;

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_ret_fifo (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_push     (r_rd_vld),
        .i_push_dat ({r_rd_tag, rom_dout}),
        .i_pop      (w_fire),
        .o_pop_dat  (w_head),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty),
        .o_count    (w_fifo_count)
    );

    assign w_head_tag   = w_head[FW-1:DATA_WIDTH];
    assign w_valid      = !w_fifo_empty;
    assign w_fire       = w_valid && w_ready;
    assign w_final_fire = w_fire && w_head_tag.last && (r_state == ST_DRAIN);

    assign w_data    = w_head[DATA_WIDTH-1:0];
    assign w_is_bias = w_valid && w_head_tag.is_bias;
    assign w_last_in = w_head_tag.last_in;
    assign w_last    = w_head_tag.last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_final_fire;
        end
    end

    assign done = r_done;
    assign busy = (r_state != ST_IDLE);

    // Credit keeps the FIFO from ever filling past its depth; full is informational.
    logic w_unused;
    assign w_unused = w_fifo_full;

endmodule
